// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: pattern mode encodings,
// default 640x480@60 timing and a helper for sizing the coordinate counters.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_WHITE = 2'd3
  } vga_mode_e;

  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;

  // Smallest counter width that holds every coordinate of the larger total.
  function automatic int vga_cnt_w(input int h_total, input int v_total);
    return (h_total > v_total) ? $clog2(h_total) : $clog2(v_total);
  endfunction

endpackage

// File: rtl/vga_pattern.sv
// Combinational test-pattern source: maps the current pixel position and
// frame mode to an RGB value; black outside the active area.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = VGA640_H_DISPLAY,
  parameter int CNT_W     = 11,
  parameter int COLOR_W   = 4
) (
  input  logic [CNT_W-1:0]   x_in,
  input  logic               y_check_in,
  input  logic               de_in,
  input  vga_mode_e          mode_in,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out
);

  localparam int BAR_W = H_DISPLAY / 8;

  logic [31:0] w_x_ext;
  logic [2:0]  w_bar;
  logic        w_check;

  assign w_x_ext = 32'(x_in);
  assign w_check = x_in[5] ^ y_check_in;

  // Bar index from constant thresholds so no divider is needed.
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (w_x_ext >= 32'(k * BAR_W)) w_bar = 3'(k);
    end
  end

  always_comb begin
    r_out = '0;
    g_out = '0;
    b_out = '0;
    if (de_in) begin
      case (mode_in)
        MODE_BARS: begin
          r_out = {COLOR_W{~w_bar[1]}};
          g_out = {COLOR_W{~w_bar[2]}};
          b_out = {COLOR_W{~w_bar[0]}};
        end
        MODE_CHECK: begin
          r_out = {COLOR_W{w_check}};
          g_out = {COLOR_W{w_check}};
          b_out = {COLOR_W{w_check}};
        end
        MODE_WHITE: begin
          r_out = '1;
          g_out = '1;
          b_out = '1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. All outputs are registered from
// the pre-edge counter position, so pixel (0,0) appears one enabled edge after reset.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_DISPLAY  = VGA640_H_DISPLAY,
  parameter int   H_FRONT    = VGA640_H_FRONT,
  parameter int   H_SYNC     = VGA640_H_SYNC,
  parameter int   H_BACK     = VGA640_H_BACK,
  parameter int   V_DISPLAY  = VGA640_V_DISPLAY,
  parameter int   V_FRONT    = VGA640_V_FRONT,
  parameter int   V_SYNC     = VGA640_V_SYNC,
  parameter int   V_BACK     = VGA640_V_BACK,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   COLOR_W    = 4,
  parameter int   CNT_W      = 11
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               en_in,
  input  logic [1:0]         mode_in,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               de_out,
  output logic [CNT_W-1:0]   x_out,
  output logic [CNT_W-1:0]   y_out,
  output logic               line_start_out,
  output logic               frame_start_out,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [CNT_W-1:0]   r_h_cnt;
  logic [CNT_W-1:0]   r_v_cnt;
  vga_mode_e          r_mode;

  logic               w_de;
  logic               w_hs_act;
  logic               w_vs_act;
  logic               w_line_start;
  logic               w_origin;
  vga_mode_e          w_mode;
  logic [COLOR_W-1:0] w_r;
  logic [COLOR_W-1:0] w_g;
  logic [COLOR_W-1:0] w_b;

  assign w_de         = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_act     = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign w_vs_act     = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign w_line_start = (r_h_cnt == '0);
  assign w_origin     = w_line_start && (r_v_cnt == '0);
  // The frame's first pixel already uses the newly sampled mode.
  assign w_mode       = w_origin ? vga_mode_e'(mode_in) : r_mode;

  vga_pattern #(
    .H_DISPLAY (H_DISPLAY),
    .CNT_W     (CNT_W),
    .COLOR_W   (COLOR_W)
  ) u_pattern (
    .x_in       (r_h_cnt),
    .y_check_in (r_v_cnt[5]),
    .de_in      (w_de),
    .mode_in    (w_mode),
    .r_out      (w_r),
    .g_out      (w_g),
    .b_out      (w_b)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_h_cnt         <= '0;
      r_v_cnt         <= '0;
      r_mode          <= MODE_BLACK;
      hsync_out       <= ~H_SYNC_POL;
      vsync_out       <= ~V_SYNC_POL;
      de_out          <= 1'b0;
      x_out           <= '0;
      y_out           <= '0;
      line_start_out  <= 1'b0;
      frame_start_out <= 1'b0;
      r_out           <= '0;
      g_out           <= '0;
      b_out           <= '0;
    end else if (en_in) begin
      hsync_out       <= w_hs_act ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_out       <= w_vs_act ? V_SYNC_POL : ~V_SYNC_POL;
      de_out          <= w_de;
      x_out           <= r_h_cnt;
      y_out           <= r_v_cnt;
      line_start_out  <= w_line_start;
      frame_start_out <= w_origin;
      r_out           <= w_r;
      g_out           <= w_g;
      b_out           <= w_b;
      r_mode          <= w_mode;
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
    end else begin
      // Frozen raster: position and levels hold, qualifiers drop.
      de_out          <= 1'b0;
      line_start_out  <= 1'b0;
      frame_start_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (640x480 default, 64x48 medium,
// 8x4 tiny with positive hsync) share one stimulus and a queued reference.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
  } exp_t;

  typedef struct {
    int   hd, hf, hs, hb;
    int   vd, vf, vs, vb;
    logic hp, vp;
  } tcfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;

  int total = 0;
  int bad   = 0;

  logic ahs, avs, ade, als, afs; logic [10:0] ax, ay; logic [3:0] ar, ag, ab;
  logic bhs, bvs, bde, bls, bfs; logic [10:0] bx, by; logic [3:0] br, bg, bb;
  logic chs, cvs, cde, cls, cfs; logic [10:0] cx, cy; logic [3:0] cr, cg, cb;

  vga_timing_gen u_dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .mode_in(mode),
    .hsync_out(ahs), .vsync_out(avs), .de_out(ade), .x_out(ax), .y_out(ay),
    .line_start_out(als), .frame_start_out(afs), .r_out(ar), .g_out(ag), .b_out(ab)
  );

  vga_timing_gen #(
    .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_DISPLAY(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)
  ) u_dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .mode_in(mode),
    .hsync_out(bhs), .vsync_out(bvs), .de_out(bde), .x_out(bx), .y_out(by),
    .line_start_out(bls), .frame_start_out(bfs), .r_out(br), .g_out(bg), .b_out(bb)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1)
  ) u_dut_c (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .mode_in(mode),
    .hsync_out(chs), .vsync_out(cvs), .de_out(cde), .x_out(cx), .y_out(cy),
    .line_start_out(cls), .frame_start_out(cfs), .r_out(cr), .g_out(cg), .b_out(cb)
  );

  exp_t act_a, act_b, act_c;
  assign act_a = {ahs, avs, ade, ax, ay, als, afs, ar, ag, ab};
  assign act_b = {bhs, bvs, bde, bx, by, bls, bfs, br, bg, bb};
  assign act_c = {chs, cvs, cde, cx, cy, cls, cfs, cr, cg, cb};

  tcfg_t cfg [3];
  int    mh  [3];
  int    mv  [3];
  logic [1:0] ml [3];
  exp_t  last[3];
  exp_t  q0[$];
  exp_t  q1[$];
  exp_t  q2[$];

  function automatic exp_t rst_val(tcfg_t t);
    exp_t e;
    e    = '0;
    e.hs = ~t.hp;
    e.vs = ~t.vp;
    return e;
  endfunction

  function automatic exp_t model(int h, int v, logic [1:0] md, tcfg_t t);
    exp_t       e;
    logic [2:0] bi;
    logic [3:0] c;
    e    = '0;
    e.x  = 11'(h);
    e.y  = 11'(v);
    e.de = (h < t.hd) && (v < t.vd);
    e.hs = (h >= t.hd + t.hf && h < t.hd + t.hf + t.hs) ? t.hp : ~t.hp;
    e.vs = (v >= t.vd + t.vf && v < t.vd + t.vf + t.vs) ? t.vp : ~t.vp;
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    if (e.de) begin
      case (md)
        2'd1: begin
          bi  = 3'(h / (t.hd / 8));
          e.r = bi[1] ? 4'h0 : 4'hF;
          e.g = bi[2] ? 4'h0 : 4'hF;
          e.b = bi[0] ? 4'h0 : 4'hF;
        end
        2'd2: begin
          c   = ((((h / 32) + (v / 32)) % 2) == 1) ? 4'hF : 4'h0;
          e.r = c; e.g = c; e.b = c;
        end
        2'd3: begin
          e.r = 4'hF; e.g = 4'hF; e.b = 4'hF;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] m);
    int htot, vtot;
    rst_n = r;
    en    = e;
    mode  = m;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      htot = cfg[i].hd + cfg[i].hf + cfg[i].hs + cfg[i].hb;
      vtot = cfg[i].vd + cfg[i].vf + cfg[i].vs + cfg[i].vb;
      if (!r) begin
        mh[i] = 0; mv[i] = 0; ml[i] = 2'd0;
        last[i] = rst_val(cfg[i]);
      end else if (e) begin
        if (mh[i] == 0 && mv[i] == 0) ml[i] = m;
        last[i] = model(mh[i], mv[i], ml[i], cfg[i]);
        mh[i]++;
        if (mh[i] == htot) begin
          mh[i] = 0;
          mv[i]++;
          if (mv[i] == vtot) mv[i] = 0;
        end
      end else begin
        last[i].de = 1'b0;
        last[i].ls = 1'b0;
        last[i].fs = 1'b0;
      end
      case (i)
        0:       q0.push_back(last[i]);
        1:       q1.push_back(last[i]);
        default: q2.push_back(last[i]);
      endcase
    end
    @(negedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input exp_t a, input exp_t e);
    total++;
    if (a !== e) begin
      bad++;
      if (bad <= 20)
        $display("FAIL %s t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b rgb=%h%h%h want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b rgb=%h%h%h",
                 nm, $time, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs, a.r, a.g, a.b,
                 e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.r, e.g, e.b);
    end
  endtask

  task automatic dchk(input string nm, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      if (bad <= 20) $display("FAIL %s t=%0t got %h want %h", nm, $time, a, e);
    end
  endtask

  // Monitor: pop one expectation per instance per cycle plus hand-computed spot checks.
  int b_frames = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() != 0) cmp("dutA", act_a, q0.pop_front());
      if (q1.size() != 0) cmp("dutB", act_b, q1.pop_front());
      if (q2.size() != 0) cmp("dutC", act_c, q2.pop_front());

      if (!rst_n) begin
        b_frames = 0;
        dchk("A reset syncs/x/y", {ahs, avs, ax, ay[2:0]}, 16'hC000);
      end else begin
        if (bfs) b_frames++;
        if (ay == 11'd0) begin
          case (ax)
            11'd0:   dchk("A bar0 white",  {4'h0, ar, ag, ab}, 16'h0FFF);
            11'd80:  dchk("A bar1 yellow", {4'h0, ar, ag, ab}, 16'h0FF0);
            11'd160: dchk("A bar2 cyan",   {4'h0, ar, ag, ab}, 16'h00FF);
            11'd560: dchk("A bar7 black",  {4'h0, ar, ag, ab}, 16'h0000);
            11'd640: dchk("A de off x640", {15'h0, ade}, 16'h0000);
            11'd655: dchk("A hs x655", {15'h0, ahs}, 16'h0001);
            11'd656: dchk("A hs x656", {15'h0, ahs}, 16'h0000);
            11'd751: dchk("A hs x751", {15'h0, ahs}, 16'h0000);
            11'd752: dchk("A hs x752", {15'h0, ahs}, 16'h0001);
            default: ;
          endcase
        end
        if (bde && bx == 11'd32 && by == 11'd0)
          dchk("B (32,0)", {4'h0, br, bg, bb}, (b_frames >= 2) ? 16'h0FFF : 16'h0F0F);
        if (bde && bx == 11'd32 && by == 11'd32)
          dchk("B (32,32)", {4'h0, br, bg, bb}, (b_frames >= 2) ? 16'h0000 : 16'h0F0F);
        if (cx == 11'd10 || cx == 11'd11) dchk("C hs active", {15'h0, chs}, 16'h0001);
        if (cx == 11'd9 || cx == 11'd12)  dchk("C hs idle",   {15'h0, chs}, 16'h0000);
      end
    end
  end

  initial begin
    cfg[0] = '{hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, hp:1'b0, vp:1'b0};
    cfg[1] = '{hd:64,  hf:4,  hs:8,  hb:4,  vd:48,  vf:2,  vs:2, vb:4,  hp:1'b0, vp:1'b0};
    cfg[2] = '{hd:8,   hf:2,  hs:2,  hb:2,  vd:4,   vf:1,  vs:1, vb:1,  hp:1'b1, vp:1'b0};
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0; mv[i] = 0; ml[i] = 2'd0;
      last[i] = rst_val(cfg[i]);
    end
    @(negedge clk);
    #1;
    repeat (10)   step(1'b0, 1'b1, 2'd1);
    repeat (101)  step(1'b1, 1'b1, 2'd1);
    repeat (5)    step(1'b1, 1'b0, 2'd1);
    repeat (2000) step(1'b1, 1'b1, 2'd1);
    repeat (7000) step(1'b1, 1'b1, 2'd2);
    repeat (3)    step(1'b0, 1'b1, 2'd1);
    repeat (900)  step(1'b1, 1'b1, 2'd1);
    repeat (2) @(negedge clk);
    #2;
    total++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL leftover expectations got %0d want 0", q0.size() + q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
